// File: rtl/soc_spi_sram_pkg.sv
// Shared constants, FSM state type and byte-mask helpers for the SPI SRAM responder.
package soc_spi_sram_pkg;

  localparam logic [7:0] SPI_CMD_READ   = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
  localparam int         MAX_FRAME_BITS = 64;
  localparam int         BIT_CNT_W      = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CSHI,
    ST_ACK,
    ST_GAP
  } sram_state_e;

  function automatic logic [1:0] mask_first(input logic [3:0] mask);
    if (mask[0])      return 2'd0;
    else if (mask[1]) return 2'd1;
    else if (mask[2]) return 2'd2;
    else              return 2'd3;
  endfunction

  function automatic logic [1:0] mask_last(input logic [3:0] mask);
    if (mask[3])      return 2'd3;
    else if (mask[2]) return 2'd2;
    else if (mask[1]) return 2'd1;
    else              return 2'd0;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/soc_spi_bit_engine.sv
// SPI mode-0 bit engine: shifts an MSB-aligned frame out on MOSI and collects
// the last 32 MISO bits; chip select is held low exactly while busy.
module soc_spi_bit_engine
  import soc_spi_sram_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [MAX_FRAME_BITS-1:0] frame,
  input  logic [BIT_CNT_W-1:0]      nbits,
  output logic                      done,
  output logic [31:0]               rx_word,
  output logic                      spi_sck,
  output logic                      spi_cs_n,
  output logic                      spi_mosi,
  input  logic                      spi_miso
);

  localparam int              DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  logic                      busy;
  logic [DIV_W-1:0]          div_cnt;
  logic [BIT_CNT_W-1:0]      bit_cnt;
  logic [MAX_FRAME_BITS-1:0] tx_sr;
  logic                      half_end;

  assign half_end = busy && (div_cnt == '0);
  // done marks the final clk cycle of the final bit, while SCK is still high
  assign done     = half_end && spi_sck && (bit_cnt == BIT_CNT_W'(1));
  assign spi_cs_n = ~busy;
  assign spi_mosi = tx_sr[MAX_FRAME_BITS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      spi_sck <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_word <= '0;
    end else if (start && !busy) begin
      busy    <= 1'b1;
      spi_sck <= 1'b0;
      div_cnt <= DIV_LOAD;
      bit_cnt <= nbits;
      tx_sr   <= frame;
    end else if (busy) begin
      if (div_cnt != '0) begin
        div_cnt <= div_cnt - 1'b1;
      end else begin
        div_cnt <= DIV_LOAD;
        if (!spi_sck) begin
          spi_sck <= 1'b1;
          rx_word <= {rx_word[30:0], spi_miso};
        end else begin
          // falling edge: next bit appears on MOSI; frame tail is zero so MOSI idles low
          spi_sck <= 1'b0;
          tx_sr   <= {tx_sr[MAX_FRAME_BITS-2:0], 1'b0};
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == BIT_CNT_W'(1)) busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/soc_spi_sram_resp.sv
// SoC SRAM bus responder: turns each bus request into one serial-SRAM SPI
// transaction and returns a one-cycle ack plus read data.
//
// state  | meaning
// IDLE   | wait for sram_cs, latch request, launch frame
// SHIFT  | bit engine clocking the frame, cs_n low
// CSHI   | one cycle cs_n high, read data captured
// ACK    | sram_ack pulse
// GAP    | request ignored while initiator drops cyc
module soc_spi_sram_resp
  import soc_spi_sram_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 24
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_data_write,
  input  logic        sram_we,
  input  logic        sram_cs,
  input  logic [3:0]  sram_wmask,
  output logic [31:0] sram_data_read,
  output logic        sram_ack,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  sram_state_e               state_q, state_d;
  logic                      we_q;
  logic                      eng_start, eng_done, load_rdata;
  logic [31:0]               rx_word;
  logic [1:0]                first_byte, last_byte;
  logic [2:0]                nbytes;
  logic [ADDR_W-1:0]         byte_base, wr_addr;
  logic [31:0]               wr_data;
  logic [MAX_FRAME_BITS-1:0] frame;
  logic [BIT_CNT_W-1:0]      nbits;
  logic                      wr_empty;
  logic                      unused_addr_bits;

  assign unused_addr_bits = ^sram_addr[31:ADDR_W-2];

  assign first_byte = mask_first(sram_wmask);
  assign last_byte  = mask_last(sram_wmask);
  assign nbytes     = 3'(last_byte) - 3'(first_byte) + 3'd1;
  assign byte_base  = {sram_addr[ADDR_W-3:0], 2'b00};
  assign wr_addr    = byte_base | ADDR_W'(first_byte);
  // bytes from first_byte upward, lowest byte transmitted first
  assign wr_data    = bswap32(sram_data_write >> {first_byte, 3'b000});
  assign frame      = sram_we ? {SPI_CMD_WRITE, wr_addr, wr_data}
                              : {SPI_CMD_READ, byte_base, 32'h0};
  assign nbits      = sram_we ? (BIT_CNT_W'(32) + BIT_CNT_W'({nbytes, 3'b000}))
                              : BIT_CNT_W'(MAX_FRAME_BITS);
  assign wr_empty   = sram_we && (sram_wmask == 4'b0000);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (sram_cs) state_d = wr_empty ? ST_ACK : ST_SHIFT;
      ST_SHIFT: if (eng_done) state_d = ST_CSHI;
      ST_CSHI:  state_d = ST_ACK;
      ST_ACK:   state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    eng_start  = (state_q == ST_IDLE) && sram_cs && !wr_empty;
    sram_ack   = (state_q == ST_ACK);
    load_rdata = (state_q == ST_CSHI) && !we_q;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q           <= 1'b0;
      sram_data_read <= '0;
    end else begin
      if ((state_q == ST_IDLE) && sram_cs) we_q <= sram_we;
      // first received byte lands in [7:0]
      if (load_rdata) sram_data_read <= bswap32(rx_word);
    end
  end

  soc_spi_bit_engine #(.CLK_DIV(CLK_DIV)) u_bit_engine (
    .clk      (clk),
    .rst_n    (i_rst_n),
    .start    (eng_start),
    .frame    (frame),
    .nbits    (nbits),
    .done     (eng_done),
    .rx_word  (rx_word),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

endmodule

// File: tb/tb_soc_spi_sram_resp.sv
// Bench for soc_spi_sram_resp with a behavioural 23LC1024-style serial SRAM.
module tb_soc_spi_sram_resp;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] sram_addr = '0;
  logic [31:0] sram_data_write = '0;
  logic        sram_we = 1'b0;
  logic        sram_cs = 1'b0;
  logic [3:0]  sram_wmask = '0;
  logic [31:0] sram_data_read;
  logic        sram_ack;
  logic        spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso;

  int checks = 0;
  int errors = 0;
  int ack_total = 0;

  soc_spi_sram_resp dut (
    .clk             (clk),
    .i_rst_n         (i_rst_n),
    .sram_addr       (sram_addr),
    .sram_data_write (sram_data_write),
    .sram_we         (sram_we),
    .sram_cs         (sram_cs),
    .sram_wmask      (sram_wmask),
    .sram_data_read  (sram_data_read),
    .sram_ack        (sram_ack),
    .spi_sck         (spi_sck),
    .spi_cs_n        (spi_cs_n),
    .spi_mosi        (spi_mosi),
    .spi_miso        (spi_miso)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sram_ack) ack_total++;

  // ---------------- serial SRAM model ----------------
  logic [7:0]  mem [0:255];
  logic [7:0]  mosi_q [$];
  int          cs_fell = 0;

  initial begin
    int          bit_cnt;
    int          p;
    logic [7:0]  sh, cmd, rb;
    logic [23:0] maddr;
    logic        sck_p, cs_p;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h40] = 8'h11; mem[8'h41] = 8'h22; mem[8'h42] = 8'h33; mem[8'h43] = 8'h44;
    spi_miso = 1'b0;
    bit_cnt = 0; sh = '0; cmd = '0; maddr = '0;
    sck_p = 1'b0; cs_p = 1'b1;
    forever begin
      @(spi_sck or spi_cs_n);
      if (!spi_cs_n && cs_p) begin
        bit_cnt = 0; cmd = 8'h00; cs_fell++;
      end
      if (spi_cs_n && !cs_p) spi_miso = 1'b0;
      if (!spi_cs_n && spi_sck && !sck_p) begin
        sh = {sh[6:0], spi_mosi};
        bit_cnt++;
        if (bit_cnt % 8 == 0) begin
          mosi_q.push_back(sh);
          if (bit_cnt == 8) cmd = sh;
          else if (bit_cnt <= 32) maddr = {maddr[15:0], sh};
          else if (cmd == 8'h02) begin
            mem[maddr[7:0]] = sh;
            maddr = maddr + 24'd1;
          end
        end
      end
      if (!spi_cs_n && !spi_sck && sck_p && cmd == 8'h03 && bit_cnt >= 32) begin
        p = bit_cnt - 32;
        rb = mem[maddr[7:0] + 8'(p / 8)];
        spi_miso = rb[7 - (p % 8)];
      end
      sck_p = spi_sck; cs_p = spi_cs_n;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  function automatic logic [63:0] mosi_since(input int q0);
    logic [63:0] v = '0;
    for (int i = 0; i < 8 && q0 + i < mosi_q.size(); i++) v[63 - 8*i -: 8] = mosi_q[q0 + i];
    return v;
  endfunction

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, output int n_ack,
                         output logic [31:0] rd_at_ack, output logic ack_next);
    @(negedge clk);
    sram_we = we; sram_addr = addr; sram_data_write = wdata; sram_wmask = mask; sram_cs = 1'b1;
    n_ack = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #1;
      if (sram_ack) begin n_ack = n; break; end
    end
    rd_at_ack = sram_data_read;
    @(negedge clk); sram_cs = 1'b0;
    @(posedge clk); #1; ack_next = sram_ack;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          exp_ack;
    logic [63:0] exp_mosi;
    int          exp_nbytes;
    logic [31:0] exp_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int          n_ack, q0, f0, a0, first_ack, second_ack;
    logic [31:0] rd;
    logic        ack_next, a259;

    vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,          4'b0000, 258, 64'h03000040_00000000, 8, 32'h44332211, 8'h40, 32'h44332211};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hA1B2C3D4,   4'b1111, 258, 64'h02000040_D4C3B2A1, 8, 32'h44332211, 8'h40, 32'hA1B2C3D4};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'h00EE0000,   4'b0100, 162, 64'h02000042_EE000000, 5, 32'h44332211, 8'h40, 32'hA1EEC3D4};
    vecs[3]  = '{1'b1, 32'h0000_0010, 32'hFFFFFFFF,   4'b0000, 1,   64'h0,                 0, 32'h44332211, 8'h40, 32'hA1EEC3D4};
    vecs[4]  = '{1'b0, 32'hFFC0_0010, 32'h0,          4'b1111, 258, 64'h03000040_00000000, 8, 32'hA1EEC3D4, 8'h40, 32'hA1EEC3D4};
    vecs[5]  = '{1'b1, 32'h0000_0020, 32'h0000BEEF,   4'b0011, 194, 64'h02000080_EFBE0000, 6, 32'hA1EEC3D4, 8'h80, 32'h0000BEEF};
    vecs[6]  = '{1'b1, 32'h0000_0020, 32'h5A000000,   4'b1000, 162, 64'h02000083_5A000000, 5, 32'hA1EEC3D4, 8'h80, 32'h5A00BEEF};
    vecs[7]  = '{1'b1, 32'h0000_0020, 32'h11223344,   4'b0101, 226, 64'h02000080_44332200, 7, 32'hA1EEC3D4, 8'h80, 32'h5A223344};
    vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0,          4'b0000, 258, 64'h03000080_00000000, 8, 32'h5A223344, 8'h80, 32'h5A223344};
    vecs[9]  = '{1'b1, 32'h0000_0021, 32'hCAFEF00D,   4'b1100, 194, 64'h02000086_FECA0000, 6, 32'h5A223344, 8'h84, 32'hCAFE0000};
    vecs[10] = '{1'b0, 32'h0000_0021, 32'h0,          4'b0000, 258, 64'h03000084_00000000, 8, 32'hCAFE0000, 8'h84, 32'hCAFE0000};

    repeat (3) @(posedge clk);
    #1;
    check("reset cs_n", 64'(spi_cs_n), 64'd1);
    check("reset sck", 64'(spi_sck), 64'd0);
    check("reset mosi", 64'(spi_mosi), 64'd0);
    check("reset ack", 64'(sram_ack), 64'd0);
    check("reset rdata", 64'(sram_data_read), 64'd0);
    @(negedge clk) i_rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 11; i++) begin
      q0 = mosi_q.size(); f0 = cs_fell;
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask, n_ack, rd, ack_next);
      check($sformatf("v%0d ack_cycle", i), 64'(n_ack), 64'(vecs[i].exp_ack));
      check($sformatf("v%0d ack_width", i), 64'(ack_next), 64'd0);
      check($sformatf("v%0d mosi_nbytes", i), 64'(mosi_q.size() - q0), 64'(vecs[i].exp_nbytes));
      check($sformatf("v%0d mosi_frame", i), mosi_since(q0), vecs[i].exp_mosi);
      check($sformatf("v%0d cs_fell", i), 64'(cs_fell - f0), (vecs[i].exp_nbytes != 0) ? 64'd1 : 64'd0);
      check($sformatf("v%0d rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      check($sformatf("v%0d mem", i), 64'(mem_word(vecs[i].mem_addr)), 64'(vecs[i].exp_mem));
    end

    // sram_cs held high across ack: GAP ignores it, then a second transaction runs
    f0 = cs_fell; first_ack = -1; second_ack = -1; a259 = 1'b1;
    @(negedge clk);
    sram_we = 1'b0; sram_addr = 32'h10; sram_wmask = 4'b0000; sram_cs = 1'b1;
    for (int n = 1; n <= 700; n++) begin
      @(posedge clk); #1;
      if (n == 259) a259 = sram_ack;
      if (sram_ack) begin
        if (first_ack < 0) first_ack = n;
        else begin second_ack = n; break; end
      end
    end
    rd = sram_data_read;
    @(negedge clk); sram_cs = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("held first_ack", 64'(first_ack), 64'd258);
    check("held gap_ack", 64'(a259), 64'd0);
    check("held second_ack", 64'(second_ack), 64'd518);
    check("held rdata", 64'(rd), 64'hA1EEC3D4);
    check("held cs_fell", 64'(cs_fell - f0), 64'd2);

    // sram_cs dropped mid-write: transaction still completes and acks
    q0 = mosi_q.size(); n_ack = -1;
    @(negedge clk);
    sram_we = 1'b1; sram_addr = 32'h30; sram_data_write = 32'h00000077; sram_wmask = 4'b0001; sram_cs = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (n == 10) sram_cs = 1'b0;
      if (sram_ack) begin n_ack = n; break; end
    end
    repeat (3) @(posedge clk); #1;
    check("drop ack_cycle", 64'(n_ack), 64'd162);
    check("drop mosi_frame", mosi_since(q0), 64'h020000C0_77000000);
    check("drop mem", 64'(mem[8'hC0]), 64'h77);
    check("drop rdata", 64'(sram_data_read), 64'hA1EEC3D4);

    // async reset at cycle 100 of a read aborts it without ack
    a0 = ack_total;
    @(negedge clk);
    sram_we = 1'b0; sram_addr = 32'h10; sram_wmask = 4'b0000; sram_cs = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("rst cs_n before", 64'(spi_cs_n), 64'd0);
    i_rst_n = 1'b0; sram_cs = 1'b0;
    #1;
    check("rst cs_n", 64'(spi_cs_n), 64'd1);
    check("rst sck", 64'(spi_sck), 64'd0);
    check("rst mosi", 64'(spi_mosi), 64'd0);
    check("rst ack", 64'(sram_ack), 64'd0);
    check("rst rdata", 64'(sram_data_read), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) i_rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("rst no_ack", 64'(ack_total - a0), 64'd0);
    run_txn(1'b0, 32'h10, 32'h0, 4'b0000, n_ack, rd, ack_next);
    check("post_rst ack_cycle", 64'(n_ack), 64'd258);
    check("post_rst rdata", 64'(rd), 64'hA1EEC3D4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
